// File: rtl/sim_bench_pkg.sv
`default_nettype none
// ============================================================================
// Package : sim_bench_pkg -- shared state, report codes and report layout
// Rev     : 1.0
// ============================================================================
package sim_bench_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_code_idle = 8'h00;
    localparam logic [7:0] c_code_run  = 8'h01;
    localparam logic [7:0] c_code_done = 8'hD0;

    localparam int c_rpt_code_lsb = 24;
    localparam int c_rpt_err_lsb  = 16;
    localparam int c_rpt_tick_lsb = 0;

endpackage : sim_bench_pkg
`default_nettype wire

// File: rtl/sim_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : sim_tick_gen -- prescaler emitting a one-cycle strobe per PRESCALE
// Rev    : 1.0
// ============================================================================
module sim_tick_gen #(
    parameter int PRESCALE = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int                 c_cnt_w = $clog2(PRESCALE);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Held at zero while disabled so the first strobe lands PRESCALE cycles after enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == c_last);

endmodule : sim_tick_gen
`default_nettype wire

// File: rtl/sim_bench_template.sv
`default_nettype none
// ============================================================================
// Module : sim_bench_template -- pattern generator with shadow checker and CI status
// Rev    : 1.0
// ============================================================================
module sim_bench_template
    import sim_bench_pkg::*;
#(
    parameter int PRESCALE    = 12,
    parameter int START_DELAY = 16,
    parameter int RUN_TICKS   = 500,
    parameter int FORCE_ERROR = 0
) (
    input  logic        refclk,
    input  logic        rst,
    output logic        template_pin,
    output logic [3:0]  template_bus,
    output logic        sim_success,
    output logic        sim_done,
    output logic [31:0] sim_report
);

    localparam int                 c_dly_w     = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [c_dly_w-1:0] c_dly_last  = c_dly_w'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [15:0]        c_run_ticks = 16'(RUN_TICKS);
    localparam logic [15:0]        c_force_at  = 16'd100;

    state_t             r_state;
    logic [c_dly_w-1:0] r_dly;
    logic [4:0]         r_shadow;
    logic [7:0]         r_err;
    logic [15:0]        r_ticks;
    logic [7:0]         r_code;
    logic               r_pend;

    logic               w_run;
    logic               w_tick;
    logic [15:0]        w_ticks_nxt;
    logic [4:0]         w_expect;
    logic               w_mismatch;

    sim_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk    (refclk),
        .rst    (rst),
        .i_en   (w_run),
        .o_tick (w_tick)
    );

    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_ticks_nxt = r_ticks + 16'd1;
        // Self-test hook: flip the expected LSB only for the check that follows tick 100.
        w_expect    = r_shadow ^ {4'd0, (FORCE_ERROR != 0) && (r_ticks == c_force_at)};
        w_mismatch  = r_pend && ({template_pin, template_bus} != w_expect);
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_dly        <= '0;
            r_shadow     <= '0;
            r_err        <= '0;
            r_ticks      <= '0;
            r_code       <= c_code_idle;
            r_pend       <= 1'b0;
            template_pin <= 1'b0;
            template_bus <= '0;
            sim_success  <= 1'b0;
            sim_done     <= 1'b0;
        end else begin
            if (w_run && w_mismatch && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_dly == c_dly_last) begin
                        r_state <= ST_RUN;
                        r_code  <= c_code_run;
                    end else begin
                        r_dly <= r_dly + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_pend <= w_tick;
                    if (w_tick) begin
                        r_shadow     <= r_shadow + 5'd1;
                        template_bus <= template_bus + 4'd1;
                        if (template_bus == 4'hF) begin
                            template_pin <= ~template_pin;
                        end
                        r_ticks <= w_ticks_nxt;
                        if (w_ticks_nxt == c_run_ticks) begin
                            r_state     <= ST_DONE;
                            r_code      <= c_code_done;
                            sim_done    <= 1'b1;
                            sim_success <= (r_err == 8'd0);
                        end
                    end
                end
                ST_DONE: begin
                    r_pend <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sim_report                          = '0;
        sim_report[c_rpt_code_lsb +: 8]     = r_code;
        sim_report[c_rpt_err_lsb  +: 8]     = r_err;
        sim_report[c_rpt_tick_lsb +: 16]    = r_ticks;
    end

endmodule : sim_bench_template
`default_nettype wire

// File: tb/tb_sim_bench_template.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_sim_bench_template -- checks a clean and a fault-injecting instance
// Rev    : 1.0
// ============================================================================
module tb_sim_bench_template;

    localparam int START = 16;
    localparam int PRE   = 12;
    localparam int TICKS = 500;

    logic        refclk = 1'b0;
    logic        rst    = 1'b0;
    int          cyc    = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic        pin_a, pin_b, succ_a, succ_b, done_a, done_b;
    logic [3:0]  bus_a, bus_b;
    logic [31:0] rep_a, rep_b;
    logic [38:0] obs_a, obs_b;

    sim_bench_template #(
        .PRESCALE (PRE), .START_DELAY (START), .RUN_TICKS (TICKS), .FORCE_ERROR (0)
    ) dut_a (
        .refclk (refclk), .rst (rst), .template_pin (pin_a), .template_bus (bus_a),
        .sim_success (succ_a), .sim_done (done_a), .sim_report (rep_a)
    );

    sim_bench_template #(
        .PRESCALE (PRE), .START_DELAY (START), .RUN_TICKS (TICKS), .FORCE_ERROR (1)
    ) dut_b (
        .refclk (refclk), .rst (rst), .template_pin (pin_b), .template_bus (bus_b),
        .sim_success (succ_b), .sim_done (done_b), .sim_report (rep_b)
    );

    assign obs_a = {pin_a, bus_a, done_a, succ_a, rep_a};
    assign obs_b = {pin_b, bus_b, done_b, succ_b, rep_b};

    always #41.667 refclk = ~refclk;

    // Rising edges seen since the last reset release.
    always @(posedge refclk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Expected {pin, bus, done, success, report} after n edges since release.
    function automatic logic [38:0] model(input int n, input bit force_err);
        int         ticks;
        logic [7:0] code;
        logic [7:0] err;
        logic       done;
        ticks = (n < START) ? 0 : (n - START) / PRE;
        if (ticks > TICKS) ticks = TICKS;
        done = (ticks == TICKS);
        code = (n < START) ? 8'h00 : (done ? 8'hD0 : 8'h01);
        err  = (force_err && (n > START + PRE * 100)) ? 8'd1 : 8'd0;
        return {ticks[4], ticks[3:0], done, done && (err == 8'd0), code, err, ticks[15:0]};
    endfunction

    task automatic advance(input int target);
        while (cyc < target) @(negedge refclk);
    endtask

    task automatic test_reset;
        logic [38:0] exp_v, obs_v;
        rst = 1'b0;
        repeat (5) begin
            @(negedge refclk);
            for (int d = 0; d < 2; d++) begin
                obs_v = d ? obs_b : obs_a;
                exp_v = model(cyc, d == 1);
                vectors++;
                if (obs_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL reset dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_startup;
        int          pts[8] = '{1, 15, 16, 17, 27, 28, 29, 40};
        logic [38:0] exp_v, obs_v;
        rst = 1'b1;
        foreach (pts[i]) begin
            advance(pts[i]);
            for (int d = 0; d < 2; d++) begin
                obs_v = d ? obs_b : obs_a;
                exp_v = model(cyc, d == 1);
                vectors++;
                if (obs_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL startup dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_wrap;
        int          pts[13];
        logic [38:0] exp_v, obs_v;
        pts[0] = 208; pts[1] = 209; pts[2] = 400; pts[3] = 1216; pts[4] = 1217;
        for (int i = 1; i <= 8; i++) pts[4 + i] = 1217 + i * 540 + int'($urandom_range(0, 400));
        foreach (pts[i]) begin
            advance(pts[i]);
            for (int d = 0; d < 2; d++) begin
                obs_v = d ? obs_b : obs_a;
                exp_v = model(cyc, d == 1);
                vectors++;
                if (obs_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL wrap dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_done;
        int          pts[14];
        logic [38:0] exp_v, obs_v;
        pts[0] = 6004; pts[1] = 6015; pts[2] = 6016; pts[13] = 7016;
        for (int i = 0; i < 10; i++) pts[3 + i] = 6016 + i * 90 + int'($urandom_range(1, 89));
        foreach (pts[i]) begin
            advance(pts[i]);
            for (int d = 0; d < 2; d++) begin
                obs_v = d ? obs_b : obs_a;
                exp_v = model(cyc, d == 1);
                vectors++;
                if (obs_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL done dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_midrun;
        int          pts[9];
        logic [38:0] exp_v, obs_v;
        // Reset from DONE first, then again at tick 250 of the fresh run.
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) advance(START + PRE * 250);
            rst = 1'b0;
            #1;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge refclk);
                for (int d = 0; d < 2; d++) begin
                    obs_v = d ? obs_b : obs_a;
                    exp_v = model(cyc, d == 1);
                    vectors++;
                    if (obs_v !== exp_v) begin
                        miscompares++;
                        $display("FAIL midrun_rst p%0d dut%0d k=%0d got=%h want=%h", phase, d, k, obs_v, exp_v);
                    end
                end
            end
            rst = 1'b1;
            if (phase == 0) begin
                advance(START + PRE * 250);
                for (int d = 0; d < 2; d++) begin
                    obs_v = d ? obs_b : obs_a;
                    exp_v = model(cyc, d == 1);
                    vectors++;
                    if (obs_v !== exp_v) begin
                        miscompares++;
                        $display("FAIL tick250 dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_v, exp_v);
                    end
                end
            end
        end
        for (int i = 0; i < 6; i++) pts[i] = 1 + i * 990 + int'($urandom_range(0, 900));
        pts[6] = 6015; pts[7] = 6016; pts[8] = 6100;
        foreach (pts[i]) begin
            advance(pts[i]);
            for (int d = 0; d < 2; d++) begin
                obs_v = d ? obs_b : obs_a;
                exp_v = model(cyc, d == 1);
                vectors++;
                if (obs_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL restart dut%0d cyc=%0d got=%h want=%h", d, cyc, obs_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_wrap();
        test_done();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sim_bench_template
`default_nettype wire

// File: doc/sim_bench_template.md
Name: sim_bench_template

Overview:
Self-checking stimulus block for the standard simulation template flow, driven by the 12 MHz reference clock.
- Generates a slow, deterministic pattern on a 1-bit pin and a 4-bit bus.
- Checks that pattern against an independent shadow counter.
- Raises the done/success/report signals that the CI harness watches; it must finish well inside the 800 us CI timeout (about 9600 refclk cycles).

Parameters:
- PRESCALE, 12, refclk cycles per tick (1 us at 12 MHz); legal range 2..65535.
- START_DELAY, 16, refclk cycles spent in IDLE after reset release before RUN.
- RUN_TICKS, 500, ticks executed in RUN before DONE; legal range 1..65535.
- FORCE_ERROR, 0, when 1 corrupts the checker's expected value on tick 100 only (checker self-test).

Ports:
- refclk  input  1  single clock; all state on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- template_pin  output  1  toggles each time template_bus wraps 15->0.
- template_bus  output  4  tick counter, increments once per tick.
- sim_success  output  1  valid when sim_done=1; 1 = zero checker errors.
- sim_done  output  1  sticky end-of-run flag.
- sim_report  output  32  status word: [31:24] state code, [23:16] error count, [15:0] tick count.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE; prescaler, delay counter, tick counter, shadow counter and error count all 0.
  - All outputs are registered.
- State machine: IDLE -> RUN -> DONE.
  - IDLE: counts START_DELAY cycles after reset release, then enters RUN. Report code 0x00.
  - RUN: code 0x01.
    - Prescaler counts 0..PRESCALE-1; a one-cycle tick strobe fires when it wraps.
    - Each tick increments template_bus (mod 16) and the 16-bit tick count.
    - On the tick where the bus goes 15->0, template_pin toggles.
    - The first tick occurs PRESCALE cycles after entering RUN.
  - DONE: code 0xD0. Entered on the cycle the tick count reaches RUN_TICKS.
    - In that same cycle, sim_done=1 and sim_success=(error count==0).
    - Outputs and report are then frozen until reset; ticks stop.
- Checker:
  - A separate 5-bit shadow counter increments on every tick.
  - One cycle after each tick, {template_pin, template_bus} is compared with the shadow value.
  - Each mismatch increments the error count, saturating at 255.
  - With FORCE_ERROR=1, the expected value's bit 0 is inverted for the comparison following tick 100 only, producing exactly one error.
- The tick count in the report is 16-bit and does not wrap, since RUN_TICKS ≤ 65535.
- A reset asserted mid-RUN or in DONE returns everything to reset values immediately; the full sequence restarts on release.
- sim_success is 0 whenever sim_done is 0.

Decomposition:
- Package sim_bench_pkg:
  - state enum (IDLE, RUN, DONE);
  - report state codes 0x00/0x01/0xD0;
  - report field bit positions.
- One sub-module, sim_tick_gen: parameterised prescaler with async active-low reset, enable input and tick-strobe output.
- Checker and FSM stay in the top.

Test Plan:
1. Hold rst=0 for 5 cycles -> all outputs 0, sim_report=0x00000000.
2. Release reset, defaults -> RUN entered after 16 cycles; first tick 12 cycles later gives template_bus=1, template_pin=0, sim_report=0x01000001.
3. Run to tick 16 -> template_bus=0, template_pin=1; at tick 32 -> bus=0, pin=0. Error field remains 0 throughout.
4. Run to completion -> at tick 500 (cycle ≈16+6000), sim_done=1, sim_success=1, sim_report=0xD00001F4; values stable for 1000 further cycles.
5. FORCE_ERROR=1 -> at DONE, sim_success=0, sim_report=0xD00101F4.
6. Assert rst=0 at tick 250, release after 3 cycles -> outputs 0 during reset; the sequence restarts and reaches DONE 6016 cycles after release with success=1.
